mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory stage of the 8-bit pipelined core, directly downstream of the execute stage.
- Holds the EX/MEM pipeline register and runs the load/store handshake to data memory.
- Generates the pipeline stall while memory is busy, and drives the MEM/WB register.
- Supplies the MEM-stage result (alu_result_mem) and WB-stage data (write_data_wb) back to execute forwarding.

Parameters:
- DATA_W, 8, data and ALU result width
- RD_W, 3, destination register index width
- TIMEOUT, 16, maximum dmem wait cycles before abort (≥2)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  squash instruction entering from EX (branch taken)
- ex_valid  in  1  EX holds a valid instruction
- ex_alu_result  in  DATA_W  ALU result / memory address (signed, used as unsigned address)
- ex_store_data  in  DATA_W  forwarded rs2 value for stores
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_reg_write  in  1  writes rd
- ex_rd  in  RD_W  destination register
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  DATA_W  address
- dmem_wdata  out  DATA_W  store data
- dmem_rdata  in  DATA_W  load data, valid when dmem_ready
- dmem_ready  in  1  access completes this cycle
- mem_stall  out  1  freeze IF/ID/EX and EX/MEM latch
- alu_result_mem  out  DATA_W  M-register ALU result (forwarding)
- write_data_wb  out  DATA_W  WB-register data (forwarding)
- wb_valid  out  1  WB register holds retired instruction
- wb_reg_write  out  1  register-file write enable
- wb_rd  out  RD_W  register-file write index
- mem_fault  out  1  one-cycle pulse on timeout abort
- fault_sticky  out  1  set by any abort, cleared only by reset

Behaviour:
- Reset: all M/WB registers, state and counter cleared; every output 0.
- M register update at posedge when mem_stall=0: m_valid = ex_valid & ~flush; other fields copied. flush=1 loads a bubble (m_valid=0). When mem_stall=1, M holds and flush is ignored, because M is older than the branch.
- Simultaneous ex_mem_read and ex_mem_write is treated as a load; dmem_we=0.
- m_mem = m_valid & (m_read | m_write).
- FSM states IDLE and WAIT; wait_cnt counts cycles spent in WAIT:
  - IDLE: if m_mem & ~dmem_ready -> WAIT, wait_cnt=1. Otherwise stay.
  - WAIT: dmem_ready -> IDLE. Else if wait_cnt == TIMEOUT-1 -> abort, IDLE. Else wait_cnt+1.
- Memory outputs: dmem_req = m_mem & ~abort. dmem_addr, dmem_wdata and dmem_we come from M and are stable for the whole request.
- Stall: mem_stall = m_mem & ~dmem_ready & ~abort, where abort = (state==WAIT) & (wait_cnt==TIMEOUT-1) & ~dmem_ready.
- Zero-wait access (dmem_ready in the first cycle) gives no stall. Total latency from ex_valid to wb_valid is 2 cycles plus wait cycles.
- WB register update at each posedge with mem_stall=0:
  - wb_valid = m_valid.
  - write_data_wb = m_read ? dmem_rdata : m_alu_result.
  - wb_rd = m_rd.
  - wb_reg_write = m_valid & m_reg_write & ~abort.
- While stalled, the WB register loads a bubble: wb_valid=0, wb_reg_write=0; write_data_wb holds its value.
- Abort: the instruction retires with wb_reg_write=0, mem_fault=1 for exactly that cycle, fault_sticky=1.
- alu_result_mem = M-register ALU result, combinational from the register. For loads this is the address; the hazard unit owns load-use stalls.
- Reset during WAIT: state returns to IDLE and M clears at that edge, so dmem_req drops in the following cycle. The memory side must tolerate the abandoned request.
- Stores: wb_valid=1, wb_reg_write follows ex_reg_write (0 for stores from decode).

Test Plan:
- ALU op: ex_alu_result=0x2A, reg_write=1, rd=3 -> alu_result_mem=0x2A at cycle 1; wb_valid=1, write_data_wb=0x2A, wb_rd=3 at cycle 2; dmem_req never high.
- Zero-wait load: addr 0x10, dmem_ready tied high, rdata=0x5C -> dmem_req one cycle, mem_stall=0, write_data_wb=0x5C next cycle.
- Load with 3 wait states: ready asserted on the 4th request cycle -> mem_stall high exactly 3 cycles; addr stable; EX inputs changed during the stall are ignored; one WB retire with the correct data.
- Store: addr 0xF0, data 0x81, 2 wait states -> dmem_we=1, wdata=0x81 held 3 cycles, wb_reg_write=0.
- Timeout, TIMEOUT=4, ready never asserted -> stall 3 cycles, mem_fault pulses once, fault_sticky=1, wb_reg_write=0, pipeline resumes.
- Flush and reset: flush with ex_valid=1 while not stalled -> bubble (wb_valid=0 two cycles later). Flush during a stall -> the M instruction still retires. Reset asserted in WAIT -> all outputs 0 after the edge.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory port of the memory stage: request/address/data out, ready/rdata back.
interface mem_stage_if #(
    parameter int DATA_W = 8
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (output req, we, addr, wdata, input rdata, ready);
    modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, dmem handshake with timeout abort, stall
// generation and the MEM/WB register.
module mem_stage #(
    parameter int DATA_W  = 8,
    parameter int RD_W    = 3,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_reg_write,
    input  logic [RD_W-1:0]   ex_rd,
    mem_stage_if.master       dmem,
    output logic              mem_stall,
    output logic [DATA_W-1:0] alu_result_mem,
    output logic [DATA_W-1:0] write_data_wb,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [RD_W-1:0]   wb_rd,
    output logic              mem_fault,
    output logic              fault_sticky
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] sdata;
        logic              rd_en;
        logic              wr_en;
        logic              reg_write;
        logic [RD_W-1:0]   rd;
    } m_reg_t;

    typedef enum logic {IDLE, WAIT} state_t;

    m_reg_t            m;
    state_t            state, state_nx;
    logic [CNT_W-1:0]  wait_cnt, cnt_nx;
    logic              m_mem;
    logic              abort;

    assign m_mem     = m.valid & (m.rd_en | m.wr_en);
    assign abort     = (state == WAIT) & (wait_cnt == CNT_LAST) & ~dmem.ready;
    assign mem_stall = m_mem & ~dmem.ready & ~abort;

    // Read wins over write when both are set, so a conflicting op behaves as a load.
    assign dmem.req       = m_mem & ~abort;
    assign dmem.we        = m.wr_en & ~m.rd_en;
    assign dmem.addr      = m.alu;
    assign dmem.wdata     = m.sdata;
    assign alu_result_mem = m.alu;

    always_comb begin
        state_nx = state;
        cnt_nx   = wait_cnt;
        case (state)
            IDLE: if (m_mem & ~dmem.ready) begin
                state_nx = WAIT;
                cnt_nx   = CNT_W'(1);
            end
            WAIT: if (dmem.ready | abort) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end else begin
                cnt_nx   = wait_cnt + CNT_W'(1);
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= cnt_nx;
        end
    end

    // M holds while stalled; the stalled instruction is older than any flushing branch.
    always_ff @(posedge clk) begin
        if (reset) begin
            m <= '0;
        end else if (!mem_stall) begin
            m <= '{valid:     ex_valid & ~flush,
                   alu:       ex_alu_result,
                   sdata:     ex_store_data,
                   rd_en:     ex_mem_read,
                   wr_en:     ex_mem_write,
                   reg_write: ex_reg_write,
                   rd:        ex_rd};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            write_data_wb <= '0;
            wb_rd         <= '0;
            mem_fault     <= 1'b0;
            fault_sticky  <= 1'b0;
        end else begin
            if (!mem_stall) begin
                wb_valid      <= m.valid;
                wb_reg_write  <= m.valid & m.reg_write & ~abort;
                write_data_wb <= m.rd_en ? dmem.rdata : m.alu;
                wb_rd         <= m.rd;
            end else begin
                wb_valid      <= 1'b0;
                wb_reg_write  <= 1'b0;
            end
            mem_fault    <= abort;
            fault_sticky <= fault_sticky | abort;
        end
    end
endmodule
